two_agent_bus_mux: RTL and testbench

- Downstream stage of the two-agent arbiter: consumes `gnt_0`/`gnt_1` and routes the granted agent's data beats onto one shared output bus.
- Locks ownership for one burst.
- Counts beats against a maximum burst length.
- Aborts stalled bursts with a watchdog.
- Releases the bus for one cycle so the arbiter can re-grant.

---
 rtl/two_agent_bus_mux_pkg.sv | 14 +
 rtl/burst_counter.sv | 39 +++
 rtl/two_agent_bus_mux.sv | 127 ++++++++++++
 tb/tb_two_agent_bus_mux.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/two_agent_bus_mux_pkg.sv
// Shared types for the two-agent bus mux: FSM state encoding and owner IDs.
package two_agent_bus_mux_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN0    = 2'd1,
    OWN1    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam logic OWNER_0 = 1'b0;
  localparam logic OWNER_1 = 1'b1;

endpackage

// File: rtl/burst_counter.sv
// Beat counter and stall watchdog for one owned burst; both clear while not owning.
module burst_counter #(
  parameter int unsigned MAX_BEATS = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic accept,
  output logic end_forced,
  output logic timeout_hit
);

  localparam int unsigned BEAT_W = $clog2(MAX_BEATS + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT);

  logic [BEAT_W-1:0] beat_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  // Accepted beats advance the burst; any stalled owned cycle advances the watchdog.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + BEAT_W'(1);
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  assign end_forced  = (beat_cnt == BEAT_W'(MAX_BEATS - 1));
  assign timeout_hit = (idle_cnt == IDLE_W'(TIMEOUT - 1));

endmodule

// File: rtl/two_agent_bus_mux.sv
// Routes the granted agent onto a shared bus, locking ownership for one burst
// with a max-length cap, a stall watchdog and a one-cycle release gap.
module two_agent_bus_mux
  import two_agent_bus_mux_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BEATS = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              gnt_0,
  input  logic              gnt_1,
  input  logic [DATA_W-1:0] data_0,
  input  logic [DATA_W-1:0] data_1,
  input  logic              valid_0,
  input  logic              valid_1,
  input  logic              last_0,
  input  logic              last_1,
  output logic              ready_0,
  output logic              ready_1,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_owner,
  output logic              busy,
  output logic              timeout_err,
  output logic              grant_err
);

  state_e state_q, state_d;
  logic   busy_d, owner_d, timeout_d, grant_err_d;
  logic   owning, accept, last_sel;
  logic   end_forced, timeout_hit;

  assign owning = (state_q == OWN0) || (state_q == OWN1);
  assign accept = bus_valid & bus_ready;

  burst_counter #(
    .MAX_BEATS (MAX_BEATS),
    .TIMEOUT   (TIMEOUT)
  ) u_burst_counter (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear       (!owning),
    .accept      (accept),
    .end_forced  (end_forced),
    .timeout_hit (timeout_hit)
  );

  // State and status registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      busy        <= 1'b0;
      bus_owner   <= OWNER_0;
      timeout_err <= 1'b0;
      grant_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy        <= busy_d;
      bus_owner   <= owner_d;
      timeout_err <= timeout_d;
      grant_err   <= grant_err_d;
    end
  end

  // Bus mux decoded from the registered state; zero-latency data path.
  always_comb begin
    bus_data  = '0;
    bus_valid = 1'b0;
    ready_0   = 1'b0;
    ready_1   = 1'b0;
    last_sel  = 1'b0;
    case (state_q)
      OWN0: begin
        bus_data  = data_0;
        bus_valid = valid_0;
        ready_0   = bus_ready;
        last_sel  = last_0;
      end
      OWN1: begin
        bus_data  = data_1;
        bus_valid = valid_1;
        ready_1   = bus_ready;
        last_sel  = last_1;
      end
      default: ;
    endcase
  end

  // Next state; grants are only looked at in IDLE so ownership stays locked.
  always_comb begin
    state_d     = state_q;
    busy_d      = 1'b0;
    owner_d     = bus_owner;
    timeout_d   = 1'b0;
    grant_err_d = grant_err | (gnt_0 & gnt_1);
    case (state_q)
      IDLE: begin
        if (gnt_0) begin
          state_d = OWN0;
          busy_d  = 1'b1;
          owner_d = OWNER_0;
        end else if (gnt_1) begin
          state_d = OWN1;
          busy_d  = 1'b1;
          owner_d = OWNER_1;
        end
      end
      OWN0, OWN1: begin
        busy_d = 1'b1;
        if (accept && (last_sel || end_forced)) begin
          state_d = RELEASE;
          busy_d  = 1'b0;
        end else if (!accept && timeout_hit) begin
          state_d   = RELEASE;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_two_agent_bus_mux.sv
// Directed vector bench for two_agent_bus_mux: per-cycle stimulus/expectation
// table plus hand sequences for watchdog, grant collision and async reset.
module tb_two_agent_bus_mux;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned MAX_BEATS = 4;
  localparam int unsigned TIMEOUT   = 16;
  localparam int          NV        = 17;

  typedef struct {
    logic       g0, g1, v0, l0, v1, l1;
    logic [7:0] d0, d1;
    logic       br;
    logic       r0, r1, bv;
    logic [7:0] bd;
    logic       bsy, own, te, ge;
  } vec_t;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              gnt_0, gnt_1, valid_0, valid_1, last_0, last_1, bus_ready;
  logic [DATA_W-1:0] data_0, data_1, bus_data;
  logic              ready_0, ready_1, bus_valid, bus_owner, busy, timeout_err, grant_err;

  int n_pass  = 0;
  int n_total = 0;

  vec_t vecs[NV];

  always #5 clock = ~clock;

  two_agent_bus_mux #(
    .DATA_W    (DATA_W),
    .MAX_BEATS (MAX_BEATS),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .gnt_0       (gnt_0),
    .gnt_1       (gnt_1),
    .data_0      (data_0),
    .data_1      (data_1),
    .valid_0     (valid_0),
    .valid_1     (valid_1),
    .last_0      (last_0),
    .last_1      (last_1),
    .ready_0     (ready_0),
    .ready_1     (ready_1),
    .bus_data    (bus_data),
    .bus_valid   (bus_valid),
    .bus_ready   (bus_ready),
    .bus_owner   (bus_owner),
    .busy        (busy),
    .timeout_err (timeout_err),
    .grant_err   (grant_err)
  );

  function automatic vec_t mk(input logic g0, g1, v0, l0, input logic [7:0] d0,
                              input logic v1, l1, input logic [7:0] d1, input logic br,
                              input logic r0, r1, bv, input logic [7:0] bd,
                              input logic bsy, own, te, ge);
    vec_t v;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.l0 = l0; v.d0 = d0;
    v.v1 = v1; v.l1 = l1; v.d1 = d1; v.br = br;
    v.r0 = r0; v.r1 = r1; v.bv = bv; v.bd = bd;
    v.bsy = bsy; v.own = own; v.te = te; v.ge = ge;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input vec_t v);
    gnt_0 = v.g0; gnt_1 = v.g1;
    valid_0 = v.v0; last_0 = v.l0; data_0 = v.d0;
    valid_1 = v.v1; last_1 = v.l1; data_1 = v.d1;
    bus_ready = v.br;
  endtask

  // Advance to just after the next rising edge, where new inputs are applied.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(mk(0,0,0,0,8'h00, 0,0,8'h00, 0, 0,0,0,8'h00, 0,0,0,0));

    // g0 g1 v0 l0 d0 | v1 l1 d1 | br || r0 r1 bv bd | busy own terr gerr
    vecs[0]  = mk(1,0,1,0,8'hA1, 0,0,8'h00, 1, 0,0,0,8'h00, 0,0,0,0);
    vecs[1]  = mk(1,0,1,0,8'hA1, 0,0,8'h00, 1, 1,0,1,8'hA1, 1,0,0,0);
    vecs[2]  = mk(1,0,1,1,8'hA2, 0,0,8'h00, 1, 1,0,1,8'hA2, 1,0,0,0);
    vecs[3]  = mk(0,0,0,0,8'h00, 0,0,8'h00, 1, 0,0,0,8'h00, 0,0,0,0);
    vecs[4]  = mk(0,1,0,0,8'h00, 1,0,8'hB1, 1, 0,0,0,8'h00, 0,0,0,0);
    vecs[5]  = mk(0,1,0,0,8'h00, 1,0,8'hB1, 1, 0,1,1,8'hB1, 1,1,0,0);
    vecs[6]  = mk(0,1,0,0,8'h00, 1,0,8'hB2, 1, 0,1,1,8'hB2, 1,1,0,0);
    vecs[7]  = mk(0,1,0,0,8'h00, 1,0,8'hB3, 1, 0,1,1,8'hB3, 1,1,0,0);
    vecs[8]  = mk(0,1,0,0,8'h00, 1,0,8'hB4, 1, 0,1,1,8'hB4, 1,1,0,0);
    vecs[9]  = mk(0,0,0,0,8'h00, 1,0,8'hB5, 1, 0,0,0,8'h00, 0,0,0,0);
    vecs[10] = mk(0,0,0,0,8'h00, 1,0,8'hB6, 1, 0,0,0,8'h00, 0,0,0,0);
    vecs[11] = mk(1,0,1,0,8'hC1, 0,0,8'h00, 1, 0,0,0,8'h00, 0,0,0,0);
    vecs[12] = mk(0,0,1,0,8'hC1, 0,0,8'h00, 1, 1,0,1,8'hC1, 1,0,0,0);
    vecs[13] = mk(0,0,1,1,8'hC2, 0,0,8'h00, 0, 0,0,1,8'hC2, 1,0,0,0);
    vecs[14] = mk(0,0,1,1,8'hC2, 0,0,8'h00, 1, 1,0,1,8'hC2, 1,0,0,0);
    vecs[15] = mk(0,0,0,0,8'h00, 0,0,8'h00, 1, 0,0,0,8'h00, 0,0,0,0);
    vecs[16] = mk(0,0,0,0,8'h00, 0,0,8'h00, 1, 0,0,0,8'h00, 0,0,0,0);

    #2;
    chk("rst busy", busy, 0);
    chk("rst bus_owner", bus_owner, 0);
    chk("rst timeout_err", timeout_err, 0);
    chk("rst grant_err", grant_err, 0);
    chk("rst bus_valid", bus_valid, 0);
    chk("rst bus_data", bus_data, 0);
    #10 reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      cyc();
      drive(vecs[i]);
      #3;
      chk($sformatf("v%0d ready_0", i), ready_0, vecs[i].r0);
      chk($sformatf("v%0d ready_1", i), ready_1, vecs[i].r1);
      chk($sformatf("v%0d bus_valid", i), bus_valid, vecs[i].bv);
      chk($sformatf("v%0d bus_data", i), bus_data, vecs[i].bd);
      chk($sformatf("v%0d busy", i), busy, vecs[i].bsy);
      chk($sformatf("v%0d timeout_err", i), timeout_err, vecs[i].te);
      chk($sformatf("v%0d grant_err", i), grant_err, vecs[i].ge);
      if (vecs[i].bsy) chk($sformatf("v%0d bus_owner", i), bus_owner, vecs[i].own);
    end

    // Watchdog: agent 0 owns the bus but never presents a beat.
    cyc();
    drive(mk(1,0,0,0,8'h00, 0,0,8'h00, 1, 0,0,0,8'h00, 0,0,0,0));
    for (int k = 1; k <= int'(TIMEOUT); k++) begin
      cyc();
      gnt_0 = 1'b0;
      #3;
      chk($sformatf("wd%0d busy", k), busy, 1);
      chk($sformatf("wd%0d timeout_err", k), timeout_err, 0);
      chk($sformatf("wd%0d bus_valid", k), bus_valid, 0);
    end
    cyc();
    #3;
    chk("wd release timeout_err", timeout_err, 1);
    chk("wd release busy", busy, 0);
    chk("wd release ready_0", ready_0, 0);
    cyc();
    #3;
    chk("wd after timeout_err", timeout_err, 0);
    chk("wd grant_err", grant_err, 0);

    // Both grants in IDLE: agent 0 wins, grant_err sticks.
    cyc();
    drive(mk(1,1,1,0,8'hD1, 1,0,8'hE1, 1, 0,0,0,8'h00, 0,0,0,0));
    #3;
    chk("ge idle busy", busy, 0);
    chk("ge idle grant_err", grant_err, 0);
    cyc();
    gnt_0 = 1'b0; gnt_1 = 1'b0;
    #3;
    chk("ge own busy", busy, 1);
    chk("ge own bus_owner", bus_owner, 0);
    chk("ge own grant_err", grant_err, 1);
    chk("ge own bus_data", bus_data, 8'hD1);
    chk("ge own ready_1", ready_1, 0);
    cyc();
    data_0 = 8'hD2;
    #3;
    chk("ge hold grant_err", grant_err, 1);
    chk("ge hold busy", busy, 1);

    // Asynchronous reset between edges in the middle of the burst.
    #2 reset_n = 1'b0;
    #1;
    chk("arst bus_valid", bus_valid, 0);
    chk("arst ready_0", ready_0, 0);
    chk("arst bus_data", bus_data, 0);
    chk("arst busy", busy, 0);
    chk("arst grant_err", grant_err, 0);
    chk("arst timeout_err", timeout_err, 0);
    @(posedge clock);
    #3 reset_n = 1'b1;
    cyc();
    #3;
    chk("post busy", busy, 0);
    chk("post bus_valid", bus_valid, 0);
    chk("post ready_0", ready_0, 0);
    cyc();
    #3;
    chk("post2 busy", busy, 0);
    chk("post2 grant_err", grant_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
